// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage.
package fetch_pkg;

  localparam int unsigned FETCH_AWIDTH = 32;
  localparam int unsigned FETCH_DWIDTH = 32;
  localparam int unsigned FETCH_DEPTH  = 4;
  localparam int unsigned INSN_BYTES   = 4;

  // Clears the byte-offset bits of a fetch address.
  localparam logic [FETCH_AWIDTH-1:0] PC_ALIGN_MASK = ~FETCH_AWIDTH'(INSN_BYTES - 1);

  // One buffered fetch: instruction plus the PC it was read from.
  typedef struct packed {
    logic [FETCH_AWIDTH-1:0] pc;
    logic [FETCH_DWIDTH-1:0] insn;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: DEPTH-entry circular FIFO with flush, count and head view.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH   = FETCH_DEPTH,
  parameter type         entry_t = fetch_entry_t
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic                       i_flush,
  input  entry_t                     i_din,
  output logic [$clog2(DEPTH):0]     o_count,
  output entry_t                     o_head_c
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  entry_t          r_mem [DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;

  assign w_full   = (r_count == CW'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_push   = i_push && !i_flush;
  assign w_pop    = i_pop && !i_flush && !w_empty;
  assign o_count  = r_count;
  assign o_head_c = r_mem[r_rptr];

  // Pointer and occupancy tracking; flush empties the buffer in one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_din;
  end

  // The issue credit rule upstream must never let a push land on a full buffer.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(w_push && w_full));

endmodule

// File: rtl/fetch_prefetch.sv
// Fetch stage: PC sequencer, credit-based memory issue and prefetch buffer
// with valid/ready toward decode and redirect flush.
module fetch_prefetch
  import fetch_pkg::*;
#(
  parameter int unsigned       DWIDTH   = FETCH_DWIDTH,
  parameter int unsigned       AWIDTH   = FETCH_AWIDTH,
  parameter logic [AWIDTH-1:0] BASEADDR = AWIDTH'(32'h0100_0000),
  parameter int unsigned       DEPTH    = FETCH_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_i,
  input  logic [AWIDTH-1:0] redirect_pc_i,
  output logic [AWIDTH-1:0] imem_addr_o,
  output logic              imem_read_en_o,
  input  logic [DWIDTH-1:0] imem_data_i,
  output logic              insn_valid_o,
  input  logic              insn_ready_i,
  output logic [AWIDTH-1:0] pc_o,
  output logic [DWIDTH-1:0] insn_o
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [AWIDTH-1:0] pc;
    logic [DWIDTH-1:0] insn;
  } entry_t;

  logic [AWIDTH-1:0] r_fpc;
  logic [AWIDTH-1:0] r_rsp_pc;
  logic              r_rsp_pend;
  logic [CW-1:0]     w_count;
  logic              w_valid;
  logic              w_issue;
  logic              w_push;
  logic              w_pop;
  entry_t            w_push_entry;
  entry_t            w_head;

  // Issue only when buffered plus in-flight entries leave room; a same-cycle
  // pop is deliberately not credited so ready never reaches read_en.
  assign w_valid      = (w_count != '0);
  assign w_issue      = !rst && !redirect_i && ((w_count + CW'(r_rsp_pend)) < CW'(DEPTH));
  assign w_push       = r_rsp_pend && !redirect_i;
  assign w_pop        = w_valid && insn_ready_i && !redirect_i;
  assign w_push_entry = '{pc: r_rsp_pc, insn: imem_data_i};

  assign imem_addr_o    = r_fpc;
  assign imem_read_en_o = w_issue;
  assign insn_valid_o   = w_valid;
  assign pc_o           = w_valid ? w_head.pc   : '0;
  assign insn_o         = w_valid ? w_head.insn : '0;

  // Fetch PC and outstanding-response tracking; redirect overrides everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fpc      <= BASEADDR;
      r_rsp_pend <= 1'b0;
      r_rsp_pc   <= '0;
    end else if (redirect_i) begin
      r_fpc      <= redirect_pc_i & ~AWIDTH'(INSN_BYTES - 1);
      r_rsp_pend <= 1'b0;
    end else if (w_issue) begin
      r_fpc      <= r_fpc + AWIDTH'(INSN_BYTES);
      r_rsp_pend <= 1'b1;
      r_rsp_pc   <= r_fpc;
    end else begin
      r_rsp_pend <= 1'b0;
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .i_push   (w_push),
    .i_pop    (w_pop),
    .i_flush  (redirect_i),
    .i_din    (w_push_entry),
    .o_count  (w_count),
    .o_head_c (w_head)
  );

endmodule

// File: tb/tb_fetch_prefetch.sv
// Scoreboard bench for fetch_prefetch: directed scenarios push expected PCs,
// a negedge monitor checks every accepted head against the queue.
module tb_fetch_prefetch;

  localparam logic [31:0] A0 = 32'h0100_0000;

  logic        clk;
  logic        rst;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] imem_addr_o;
  logic        imem_read_en_o;
  logic [31:0] imem_data_i;
  logic        insn_valid_o;
  logic        insn_ready_i;
  logic [31:0] pc_o;
  logic [31:0] insn_o;

  int          n_vec;
  int          n_err;
  logic [31:0] sb[$];

  fetch_prefetch dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_i     (redirect_i),
    .redirect_pc_i  (redirect_pc_i),
    .imem_addr_o    (imem_addr_o),
    .imem_read_en_o (imem_read_en_o),
    .imem_data_i    (imem_data_i),
    .insn_valid_o   (insn_valid_o),
    .insn_ready_i   (insn_ready_i),
    .pc_o           (pc_o),
    .insn_o         (insn_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
  endfunction

  // Instruction memory model: one-cycle read latency.
  initial imem_data_i = '0;
  always @(posedge clk) begin
    if (imem_read_en_o) imem_data_i <= mem_f(imem_addr_o);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) sb.push_back(start + 32'(4 * i));
  endtask

  // Monitor: every head accepted by decode must match the next expected PC.
  always @(negedge clk) begin
    if (!rst && !redirect_i && insn_valid_o && insn_ready_i) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_pop: got pc 0x%0h expected none", pc_o);
      end else begin
        logic [31:0] e;
        e = sb.pop_front();
        check("pop_pc", 64'(pc_o), 64'(e));
        check("pop_insn", 64'(insn_o), 64'(mem_f(e)));
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_read_en"}, 64'(imem_read_en_o), 64'(0));
    check({tag, "_valid"}, 64'(insn_valid_o), 64'(0));
    check({tag, "_pc"}, 64'(pc_o), 64'(0));
    check({tag, "_insn"}, 64'(insn_o), 64'(0));
    check({tag, "_addr"}, 64'(imem_addr_o), 64'(A0));
  endtask

  // Off-edge async reset, hold two edges, release just after a posedge.
  task automatic do_reset(input string tag);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_reset_vals(tag);
    check({tag, "_sb_empty"}, 64'(sb.size()), 64'(0));
    sb.delete();
    insn_ready_i = 1'b0;
    redirect_i   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    redirect_i = 1'b0;
    redirect_pc_i = '0;
    insn_ready_i = 1'b1;
    #2;
    check_reset_vals("por");

    // Scenario 1: ready from start, 1 insn/cycle after a 2-cycle latency.
    push_exp(A0, 5);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("t1_c1_read_en", 64'(imem_read_en_o), 64'(1));
    check("t1_c1_addr", 64'(imem_addr_o), 64'(A0));
    check("t1_c1_valid", 64'(insn_valid_o), 64'(0));
    @(negedge clk);
    check("t1_c2_addr", 64'(imem_addr_o), 64'(A0 + 32'h4));
    check("t1_c2_valid", 64'(insn_valid_o), 64'(0));
    @(negedge clk);
    check("t1_c3_valid", 64'(insn_valid_o), 64'(1));
    check("t1_c3_pc", 64'(pc_o), 64'(A0));
    repeat (5) @(posedge clk);
    #1;
    insn_ready_i = 1'b0;

    // Scenario 2: stalled decode; exactly DEPTH reads, then ordered drain.
    do_reset("rst2");
    begin
      logic [31:0] rd[$];
      for (int c = 1; c <= 10; c++) begin
        @(negedge clk);
        if (imem_read_en_o) rd.push_back(imem_addr_o);
        if (c == 6 || c == 10) begin
          check("t2_head_valid", 64'(insn_valid_o), 64'(1));
          check("t2_head_pc", 64'(pc_o), 64'(A0));
        end
      end
      check("t2_nreads", 64'(rd.size()), 64'(4));
      for (int i = 0; i < rd.size() && i < 4; i++)
        check("t2_read_addr", 64'(rd[i]), 64'(A0 + 32'(4 * i)));
    end
    push_exp(A0, 8);
    @(posedge clk);
    #1;
    insn_ready_i = 1'b1;
    @(negedge clk);
    check("t2_no_credit_pop", 64'(imem_read_en_o), 64'(0));
    @(negedge clk);
    check("t2_resume_en", 64'(imem_read_en_o), 64'(1));
    check("t2_resume_addr", 64'(imem_addr_o), 64'(A0 + 32'h10));
    repeat (7) @(posedge clk);
    #1;
    insn_ready_i = 1'b0;

    // Scenario 3: redirect with 3 buffered and one response in flight.
    do_reset("rst3");
    repeat (4) @(posedge clk);
    #1;
    redirect_i = 1'b1;
    redirect_pc_i = 32'h0100_0102;
    @(negedge clk);
    check("t3_pre_valid", 64'(insn_valid_o), 64'(1));
    check("t3_redir_no_issue", 64'(imem_read_en_o), 64'(0));
    @(posedge clk);
    #1;
    redirect_i = 1'b0;
    insn_ready_i = 1'b1;
    push_exp(32'h0100_0100, 3);
    @(negedge clk);
    check("t3_flushed_valid", 64'(insn_valid_o), 64'(0));
    check("t3_target_addr", 64'(imem_addr_o), 64'(32'h0100_0100));
    check("t3_target_en", 64'(imem_read_en_o), 64'(1));
    @(negedge clk);
    check("t3_c7_valid", 64'(insn_valid_o), 64'(0));
    @(negedge clk);
    check("t3_c8_valid", 64'(insn_valid_o), 64'(1));
    check("t3_c8_pc", 64'(pc_o), 64'(32'h0100_0100));
    repeat (3) @(posedge clk);
    #1;
    insn_ready_i = 1'b0;

    // Scenario 4: push and pop on the same edge keep occupancy constant.
    do_reset("rst4");
    repeat (4) @(posedge clk);
    #1;
    insn_ready_i = 1'b1;
    push_exp(A0, 1);
    @(negedge clk);
    @(posedge clk);
    #1;
    insn_ready_i = 1'b0;
    @(negedge clk);
    check("t4_refill_en", 64'(imem_read_en_o), 64'(1));
    check("t4_refill_addr", 64'(imem_addr_o), 64'(A0 + 32'h10));
    @(negedge clk);
    check("t4_c7_read_en", 64'(imem_read_en_o), 64'(0));
    repeat (3) @(negedge clk);
    check("t4_full_read_en", 64'(imem_read_en_o), 64'(0));
    check("t4_full_valid", 64'(insn_valid_o), 64'(1));
    check("t4_full_pc", 64'(pc_o), 64'(A0 + 32'h4));
    push_exp(A0 + 32'h4, 4);
    @(posedge clk);
    #1;
    insn_ready_i = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    insn_ready_i = 1'b0;
    check("t4_drained", 64'(sb.size()), 64'(0));

    // Scenario 5: redirect to the top of the address space, PC wraps to 0.
    @(posedge clk);
    #1;
    redirect_i = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFC;
    insn_ready_i = 1'b1;
    sb.push_back(32'hFFFF_FFFC);
    sb.push_back(32'h0000_0000);
    sb.push_back(32'h0000_0004);
    @(posedge clk);
    #1;
    redirect_i = 1'b0;
    @(negedge clk);
    check("t5_addr_top", 64'(imem_addr_o), 64'(32'hFFFF_FFFC));
    check("t5_valid_flushed", 64'(insn_valid_o), 64'(0));
    @(negedge clk);
    check("t5_addr_wrap", 64'(imem_addr_o), 64'(32'h0000_0000));
    check("t5_wrap_en", 64'(imem_read_en_o), 64'(1));
    @(negedge clk);
    check("t5_first_pc", 64'(pc_o), 64'(32'hFFFF_FFFC));
    repeat (3) @(posedge clk);
    #1;
    insn_ready_i = 1'b0;

    // Scenario 6: async reset with a non-empty buffer, then clean restart.
    repeat (4) @(negedge clk);
    check("t6_pre_valid", 64'(insn_valid_o), 64'(1));
    do_reset("rst6");
    @(negedge clk);
    check("t6_restart_en", 64'(imem_read_en_o), 64'(1));
    check("t6_restart_addr", 64'(imem_addr_o), 64'(A0));
    @(negedge clk);
    check("t6_restart_addr2", 64'(imem_addr_o), 64'(A0 + 32'h4));
    @(negedge clk);
    check("t6_restart_pc", 64'(pc_o), 64'(A0));
    check("t6_restart_insn", 64'(insn_o), 64'(mem_f(A0)));
    check("final_sb_empty", 64'(sb.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
